// File: rtl/multicycle_maindec_if.sv
// Control bus between the multicycle main decoder and its datapath.
//
// Decoder inputs (driven by the datapath / instruction register side):
//   op        [6:0]  opcode field of the instruction register
//   funct3    [2:0]  funct3 field of the instruction register
//   mem_ready        memory completes its access this cycle
//
// Decoder outputs (consumed by the datapath):
//   PCUpdate, IRWrite, MemWrite, RegWrite, Branch   write/branch strobes
//   AdrSrc           memory address select, 0 = PC, 1 = ALU result register
//   ResultSrc [1:0]  result mux select
//   ALUSrcA   [1:0]  00 PC, 01 oldPC, 10 rs1, 11 zero
//   ALUSrcB   [1:0]  ALU operand B select
//   ALUOp     [1:0]  ALU operation class
//   ImmSrc    [2:0]  000 I, 001 S, 010 B, 011 J, 100 U, 111 none
//   BranchCond[2:0]  funct3 forwarded to the branch comparator while Branch=1
//
// The decoder connects through the slave modport; the datapath (or a bench)
// connects through the master modport.
interface multicycle_maindec_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_ready;

    logic       PCUpdate;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       Branch;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic [2:0] BranchCond;

    modport master (
        output op, funct3, mem_ready,
        input  PCUpdate, IRWrite, MemWrite, RegWrite, Branch, AdrSrc,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, BranchCond
    );

    modport slave (
        input  op, funct3, mem_ready,
        output PCUpdate, IRWrite, MemWrite, RegWrite, Branch, AdrSrc,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, BranchCond
    );
endinterface

// File: rtl/multicycle_maindec.sv
// Main control decoder for a multicycle RV32 subset datapath.
//
// A Moore FSM steps each instruction through fetch, decode and its execute
// states, driving the datapath selects and write strobes over the control
// bus. It also counts retired instructions and flags unsupported opcodes.
//
// Parameters:
//   MEM_WAIT    1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready,
//               0 = mem_ready ignored (memory always ready)
//   FULL_BRANCH 1 = branch funct3 000/001/100/101/110/111 accepted,
//               0 = only 000/100 accepted
//   CNT_W       width of the retired-instruction counter
//
// Ports:
//   clk            rising-edge clock
//   resetn         synchronous active-low reset
//   bus            control bus (slave side), see multicycle_maindec_if
//   illegal_instr  sticky, set once an unsupported instruction is decoded
//   instr_done     one-cycle pulse in the final state of each instruction
//   instret        retired-instruction count, wraps modulo 2^CNT_W
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | read registers, compute branch/jump target oldPC+imm
// MEMADR   | compute load/store address rs1+imm
// MEMREAD  | load data read, waits for memory
// MEMWB    | write load data to rd, instruction retires
// MEMWRITE | store data write, waits for memory, retires on ready
// EXECR    | ALU op rs1,rs2
// EXECI    | ALU op rs1,imm
// ALUWB    | write ALU result to rd, instruction retires
// BRANCH   | compare rs1/rs2, PC <= target if taken, instruction retires
// JAL      | PC <= target, ALU forms oldPC+4 for the link register
// LUI      | ALU forms 0+imm
// ILLEGAL  | unsupported instruction, parked until reset
module multicycle_maindec #(
    parameter int MEM_WAIT    = 1,
    parameter int FULL_BRANCH = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    multicycle_maindec_if.slave bus,
    output logic             illegal_instr,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        LUI,
        ILLEGAL
    } state_t;

    state_t     state;
    state_t     nxt;
    logic       mem_rdy;

    // Registered per-state outputs, loaded from the next state so they line
    // up with the state register.
    logic       adrsrc_q;
    logic [1:0] resultsrc_q;
    logic [1:0] alusrca_q;
    logic [1:0] alusrcb_q;
    logic [1:0] aluop_q;
    logic       fetch_q;
    logic       memwr_q;
    logic       regwr_q;
    logic       branch_q;
    logic       jal_q;
    logic       done_q;
    logic       illegal_q;

    assign mem_rdy = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

    function automatic logic branch_ok(input logic [2:0] f3);
        if (FULL_BRANCH != 0) begin
            return !((f3 == 3'b010) || (f3 == 3'b011));
        end
        return (f3 == 3'b000) || (f3 == 3'b100);
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            FETCH: begin
                if (mem_rdy) nxt = DECODE;
            end
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_RTYPE:          nxt = EXECR;
                    OP_ITYPE:          nxt = EXECI;
                    OP_BRANCH:         nxt = branch_ok(bus.funct3) ? BRANCH : ILLEGAL;
                    OP_JAL:            nxt = JAL;
                    OP_LUI:            nxt = LUI;
                    default:           nxt = ILLEGAL;
                endcase
            end
            MEMADR:   nxt = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (mem_rdy) nxt = MEMWB;
            end
            MEMWRITE: begin
                if (mem_rdy) nxt = FETCH;
            end
            MEMWB, ALUWB, BRANCH:   nxt = FETCH;
            EXECR, EXECI, LUI, JAL: nxt = ALUWB;
            ILLEGAL:                nxt = ILLEGAL;
            default:                nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= FETCH;
            instret     <= '0;
            illegal_q   <= 1'b0;
            adrsrc_q    <= 1'b0;
            resultsrc_q <= 2'b10;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b10;
            aluop_q     <= 2'b00;
            fetch_q     <= 1'b1;
            memwr_q     <= 1'b0;
            regwr_q     <= 1'b0;
            branch_q    <= 1'b0;
            jal_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state <= nxt;
            if (instr_done) begin
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            adrsrc_q    <= 1'b0;
            resultsrc_q <= 2'b00;
            alusrca_q   <= 2'b00;
            alusrcb_q   <= 2'b00;
            aluop_q     <= 2'b00;
            fetch_q     <= 1'b0;
            memwr_q     <= 1'b0;
            regwr_q     <= 1'b0;
            branch_q    <= 1'b0;
            jal_q       <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= illegal_q || (nxt == ILLEGAL);

            case (nxt)
                FETCH: begin
                    resultsrc_q <= 2'b10;
                    alusrcb_q   <= 2'b10;
                    fetch_q     <= 1'b1;
                end
                DECODE: begin
                    alusrca_q <= 2'b01;
                    alusrcb_q <= 2'b01;
                end
                MEMADR: begin
                    alusrca_q <= 2'b10;
                    alusrcb_q <= 2'b01;
                end
                MEMREAD: begin
                    adrsrc_q <= 1'b1;
                end
                MEMWB: begin
                    resultsrc_q <= 2'b01;
                    regwr_q     <= 1'b1;
                    done_q      <= 1'b1;
                end
                MEMWRITE: begin
                    adrsrc_q <= 1'b1;
                    memwr_q  <= 1'b1;
                end
                EXECR: begin
                    alusrca_q <= 2'b10;
                    aluop_q   <= 2'b10;
                end
                EXECI: begin
                    alusrca_q <= 2'b10;
                    alusrcb_q <= 2'b01;
                    aluop_q   <= 2'b10;
                end
                ALUWB: begin
                    regwr_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                BRANCH: begin
                    alusrca_q <= 2'b10;
                    aluop_q   <= 2'b01;
                    branch_q  <= 1'b1;
                    done_q    <= 1'b1;
                end
                JAL: begin
                    alusrca_q <= 2'b01;
                    alusrcb_q <= 2'b10;
                    jal_q     <= 1'b1;
                end
                LUI: begin
                    alusrca_q <= 2'b11;
                    alusrcb_q <= 2'b01;
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes that depend on the memory handshake are qualified with
    // mem_ready in the same cycle; everything is forced to the idle FETCH
    // picture while resetn is low so no write leaks out during reset.
    assign bus.IRWrite    = resetn && fetch_q && mem_rdy;
    assign bus.PCUpdate   = resetn && ((fetch_q && mem_rdy) || jal_q);
    assign bus.MemWrite   = resetn && memwr_q;
    assign bus.RegWrite   = resetn && regwr_q;
    assign bus.Branch     = resetn && branch_q;
    assign bus.BranchCond = (resetn && branch_q) ? bus.funct3 : 3'b000;
    assign bus.AdrSrc     = resetn && adrsrc_q;
    assign bus.ResultSrc  = resetn ? resultsrc_q : 2'b10;
    assign bus.ALUSrcA    = resetn ? alusrca_q   : 2'b00;
    assign bus.ALUSrcB    = resetn ? alusrcb_q   : 2'b10;
    assign bus.ALUOp      = resetn ? aluop_q     : 2'b00;

    assign instr_done    = resetn && (done_q || (memwr_q && mem_rdy));
    assign illegal_instr = illegal_q;

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (bus.op)
            OP_LOAD, OP_ITYPE: bus.ImmSrc = 3'b000;
            OP_STORE:          bus.ImmSrc = 3'b001;
            OP_BRANCH:         bus.ImmSrc = 3'b010;
            OP_JAL:            bus.ImmSrc = 3'b011;
            OP_LUI:            bus.ImmSrc = 3'b100;
            default:           bus.ImmSrc = 3'b111;
        endcase
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
module tb_multicycle_maindec;

    typedef struct packed {
        logic       pcu;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       br;
        logic       adr;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [2:0] imm;
        logic [2:0] bc;
        logic       ill;
        logic       done;
    } ctl_t;

    // Instruction steps named after the behaviour table.
    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6;
    localparam int EI = 7, AWB = 8, BR = 9, J = 10, L = 11, ILL = 12;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JALO = 7'b1101111;
    localparam logic [6:0] LUIO = 7'b0110111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_v [2];
    logic [6:0] op_v   [2];
    logic [2:0] f3_v   [2];
    logic       mr_v   [2];

    int checks = 0;
    int failures = 0;

    multicycle_maindec_if bus_a ();
    multicycle_maindec_if bus_b ();

    assign bus_a.op = op_v[0];
    assign bus_a.funct3 = f3_v[0];
    assign bus_a.mem_ready = mr_v[0];
    assign bus_b.op = op_v[1];
    assign bus_b.funct3 = f3_v[1];
    assign bus_b.mem_ready = mr_v[1];

    logic        ill_a, done_a, ill_b, done_b;
    logic [31:0] ir_a;
    logic [3:0]  ir_b;

    multicycle_maindec #(.MEM_WAIT(1), .FULL_BRANCH(1), .CNT_W(32)) dut_a (
        .clk(clk), .resetn(rstn_v[0]), .bus(bus_a),
        .illegal_instr(ill_a), .instr_done(done_a), .instret(ir_a)
    );

    multicycle_maindec #(.MEM_WAIT(0), .FULL_BRANCH(0), .CNT_W(4)) dut_b (
        .clk(clk), .resetn(rstn_v[1]), .bus(bus_b),
        .illegal_instr(ill_b), .instr_done(done_b), .instret(ir_b)
    );

    ctl_t act_a, act_b;
    assign act_a = {bus_a.PCUpdate, bus_a.IRWrite, bus_a.MemWrite, bus_a.RegWrite,
                    bus_a.Branch, bus_a.AdrSrc, bus_a.ResultSrc, bus_a.ALUSrcA,
                    bus_a.ALUSrcB, bus_a.ALUOp, bus_a.ImmSrc, bus_a.BranchCond,
                    ill_a, done_a};
    assign act_b = {bus_b.PCUpdate, bus_b.IRWrite, bus_b.MemWrite, bus_b.RegWrite,
                    bus_b.Branch, bus_b.AdrSrc, bus_b.ResultSrc, bus_b.ALUSrcA,
                    bus_b.ALUSrcB, bus_b.ALUOp, bus_b.ImmSrc, bus_b.BranchCond,
                    ill_b, done_b};

    // ---------------- behavioural model ----------------
    int          step [2];
    int          pl   [2][3];
    int          plen [2];
    int          pidx [2];
    bit          vld  [2];
    logic [31:0] cnt  [2];

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == LW || o == ADDI) return 3'b000;
        if (o == SW)   return 3'b001;
        if (o == BEQ)  return 3'b010;
        if (o == JALO) return 3'b011;
        if (o == LUIO) return 3'b100;
        return 3'b111;
    endfunction

    function automatic ctl_t expect_ctl(input int s, input logic mre, input logic rn,
                                        input logic [6:0] o, input logic [2:0] f3);
        ctl_t e;
        e = '0;
        e.imm = imm_of(o);
        e.ill = (s == ILL);
        if (!rn) begin
            e.rs = 2'b10;
            e.b  = 2'b10;
            return e;
        end
        case (s)
            F:   begin e.rs = 2'b10; e.b = 2'b10; e.irw = mre; e.pcu = mre; end
            D:   begin e.a = 2'b01; e.b = 2'b01; end
            MA:  begin e.a = 2'b10; e.b = 2'b01; end
            MR:  begin e.adr = 1'b1; end
            MWB: begin e.rs = 2'b01; e.regw = 1'b1; e.done = 1'b1; end
            MW:  begin e.adr = 1'b1; e.memw = 1'b1; e.done = mre; end
            ER:  begin e.a = 2'b10; e.aop = 2'b10; end
            EI:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
            AWB: begin e.regw = 1'b1; e.done = 1'b1; end
            BR:  begin e.a = 2'b10; e.aop = 2'b01; e.br = 1'b1; e.bc = f3; e.done = 1'b1; end
            J:   begin e.a = 2'b01; e.b = 2'b10; e.pcu = 1'b1; end
            L:   begin e.a = 2'b11; e.b = 2'b01; end
            default: begin end
        endcase
        return e;
    endfunction

    // Remaining steps of an instruction once its opcode is known.
    task automatic route(input int d, input logic [6:0] o, input logic [2:0] f3);
        bit ok;
        ok = (d == 0) ? (f3 != 3'b010 && f3 != 3'b011) : (f3 == 3'b000 || f3 == 3'b100);
        plen[d] = 1;
        pl[d][0] = ILL;
        if (o == LW)        begin pl[d][0] = MA; pl[d][1] = MR; pl[d][2] = MWB; plen[d] = 3; end
        else if (o == SW)   begin pl[d][0] = MA; pl[d][1] = MW; plen[d] = 2; end
        else if (o == RT)   begin pl[d][0] = ER; pl[d][1] = AWB; plen[d] = 2; end
        else if (o == ADDI) begin pl[d][0] = EI; pl[d][1] = AWB; plen[d] = 2; end
        else if (o == BEQ)  begin pl[d][0] = ok ? BR : ILL; end
        else if (o == JALO) begin pl[d][0] = J; pl[d][1] = AWB; plen[d] = 2; end
        else if (o == LUIO) begin pl[d][0] = L; pl[d][1] = AWB; plen[d] = 2; end
    endtask

    // Compare every falling edge, then advance the model with the inputs the
    // DUT will sample on the coming rising edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            step[d] = F; vld[d] = 0; cnt[d] = 0; plen[d] = 0; pidx[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ctl_t        ac, ec;
                logic [31:0] ai;
                logic        mre;
                bit          hold;
                ac  = (d == 0) ? act_a : act_b;
                ai  = (d == 0) ? ir_a : {28'd0, ir_b};
                mre = (d == 0) ? mr_v[0] : 1'b1;
                ec  = expect_ctl(step[d], mre, rstn_v[d], op_v[d], f3_v[d]);
                if (vld[d]) begin
                    checks++;
                    if (ac !== ec) begin
                        failures++;
                        $display("FAIL model_ctl dut%0d t=%0t got=%h exp=%h", d, $time, ac, ec);
                    end
                    checks++;
                    if (ai !== cnt[d]) begin
                        failures++;
                        $display("FAIL model_instret dut%0d t=%0t got=%0d exp=%0d", d, $time, ai, cnt[d]);
                    end
                end
                if (!rstn_v[d]) begin
                    step[d] = F; cnt[d] = 0; vld[d] = 1;
                end else begin
                    if (ec.done) cnt[d] = (cnt[d] + 1) & ((d == 0) ? 32'hFFFF_FFFF : 32'h0000_000F);
                    hold = (step[d] == ILL) || ((step[d] == F || step[d] == MR || step[d] == MW) && !mre);
                    if (hold) begin
                    end else if (step[d] == F) begin
                        step[d] = D;
                    end else if (step[d] == D) begin
                        route(d, op_v[d], f3_v[d]);
                        step[d] = pl[d][0];
                        pidx[d] = 1;
                    end else if (pidx[d] < plen[d]) begin
                        step[d] = pl[d][pidx[d]];
                        pidx[d] = pidx[d] + 1;
                    end else begin
                        step[d] = F;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    ctl_t first_ctl, last_ctl;
    int   last_mwc;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Called at posedge+2 with the DUT in FETCH; returns at posedge+2.
    // mem_ready (dut0 only) is low for cycles lf..lf+ln-1 of the instruction.
    task automatic exec(input int d, input logic [6:0] o, input logic [2:0] f,
                        input int lf, input int ln, input int exp_lat, input string nm);
        int cyc;
        bit got;
        ctl_t c;
        op_v[d] = o;
        f3_v[d] = f;
        got = 0;
        cyc = 0;
        last_mwc = 0;
        while (!got && cyc < 40) begin
            cyc++;
            if (d == 0) mr_v[0] = !(cyc >= lf && cyc < lf + ln);
            @(negedge clk);
            c = (d == 0) ? act_a : act_b;
            if (cyc == 1) first_ctl = c;
            if (c.memw) last_mwc++;
            if (c.done) begin
                got = 1;
                last_ctl = c;
            end
            @(posedge clk);
            #2;
        end
        if (d == 0) mr_v[0] = 1'b1;
        chk({nm, "_latency"}, got ? cyc : 0, exp_lat);
    endtask

    initial begin
        int   sv;
        int   cnt_s;
        bit   rw;
        ctl_t c;
        for (int d = 0; d < 2; d++) begin
            rstn_v[d] = 1'b0; op_v[d] = 7'd0; f3_v[d] = 3'd0;
        end
        mr_v[0] = 1'b1;
        mr_v[1] = 1'b0;   // ignored by dut_b
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_instret", ir_a, 0);
        chk("reset_illegal", {31'd0, ill_a}, 0);
        chk("reset_irwrite", {31'd0, act_a.irw}, 0);
        chk("reset_resultsrc", {30'd0, act_a.rs}, 2'b10);
        chk("reset_alusrcb", {30'd0, act_a.b}, 2'b10);
        @(posedge clk);
        #2;

        // ---- dut_b: MEM_WAIT=0, FULL_BRANCH=0, CNT_W=4 ----
        rstn_v[1] = 1'b1;
        exec(1, LW, 3'b010, 0, 0, 5, "b_lw");
        chk("b_lw_regwrite", {31'd0, last_ctl.regw}, 1);
        chk("b_lw_resultsrc", {30'd0, last_ctl.rs}, 2'b01);
        chk("b_lw_instret", {28'd0, ir_b}, 1);
        exec(1, SW, 3'b010, 0, 0, 4, "b_sw");
        exec(1, RT, 3'b000, 0, 0, 4, "b_r");
        exec(1, ADDI, 3'b000, 0, 0, 4, "b_addi");
        exec(1, LUIO, 3'b000, 0, 0, 4, "b_lui");
        exec(1, BEQ, 3'b000, 0, 0, 3, "b_beq");
        exec(1, BEQ, 3'b100, 0, 0, 3, "b_blt");
        exec(1, JALO, 3'b000, 0, 0, 4, "b_jal");
        chk("b_jal_pcupdate_first", {31'd0, first_ctl.pcu}, 1);
        chk("b_instret8", {28'd0, ir_b}, 8);

        op_v[1] = BEQ;
        f3_v[1] = 3'b101;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
        end
        chk("b_bge_illegal", {31'd0, ill_b}, 1);
        rstn_v[1] = 1'b0;
        op_v[1] = ADDI;
        f3_v[1] = 3'b000;
        @(posedge clk);
        #2;
        rstn_v[1] = 1'b1;
        chk("b_reset_clears_illegal", {31'd0, ill_b}, 0);
        for (int i = 0; i < 15; i++) exec(1, ADDI, 3'b000, 0, 0, 4, "b_addi_run");
        chk("b_instret15", {28'd0, ir_b}, 15);
        exec(1, ADDI, 3'b000, 0, 0, 4, "b_addi_wrap");
        chk("b_instret_wrap", {28'd0, ir_b}, 0);
        rstn_v[1] = 1'b0;

        // ---- dut_a: MEM_WAIT=1, FULL_BRANCH=1, CNT_W=32 ----
        rstn_v[0] = 1'b1;
        exec(0, LW, 3'b010, 1, 2, 7, "a_lw_fetchwait");
        exec(0, SW, 3'b010, 4, 3, 7, "a_sw_wait");
        chk("a_sw_memwrite_cycles", last_mwc, 4);
        chk("a_instret2", ir_a, 2);
        exec(0, BEQ, 3'b101, 0, 0, 3, "a_bge");
        chk("a_bge_branch", {31'd0, last_ctl.br}, 1);
        chk("a_bge_cond", {29'd0, last_ctl.bc}, 3'b101);
        exec(0, BEQ, 3'b110, 0, 0, 3, "a_bltu");

        // reset while a load waits in MEMREAD
        op_v[0] = LW;
        f3_v[0] = 3'b010;
        rw = 0;
        for (int cy = 1; cy <= 5; cy++) begin
            mr_v[0] = (cy < 4);
            @(negedge clk);
            if (act_a.regw) rw = 1;
            @(posedge clk);
            #2;
        end
        rstn_v[0] = 1'b0;
        @(negedge clk);
        c = act_a;
        if (c.regw) rw = 1;
        chk("a_rst_mid_adrsrc", {31'd0, c.adr}, 0);
        chk("a_rst_mid_resultsrc", {30'd0, c.rs}, 2'b10);
        @(posedge clk);
        #2;
        rstn_v[0] = 1'b1;
        mr_v[0] = 1'b1;
        chk("a_rst_mid_no_regwrite", {31'd0, rw}, 0);
        chk("a_rst_mid_instret", ir_a, 0);
        exec(0, ADDI, 3'b000, 0, 0, 4, "a_addi_after_rst");
        chk("a_fetch_after_rst", {31'd0, first_ctl.irw}, 1);

        // unsupported opcode parks the decoder
        sv = ir_a;
        cnt_s = 0;
        op_v[0] = 7'b1111111;
        for (int cy = 1; cy <= 12; cy++) begin
            @(negedge clk);
            c = act_a;
            if (cy >= 3 && (c.pcu || c.irw || c.memw || c.regw || c.br || c.done)) cnt_s++;
            @(posedge clk);
            #2;
        end
        chk("a_illegal_flag", {31'd0, ill_a}, 1);
        chk("a_illegal_no_strobes", cnt_s, 0);
        chk("a_illegal_instret_frozen", ir_a, sv);
        rstn_v[0] = 1'b0;
        op_v[0] = ADDI;
        @(posedge clk);
        #2;
        rstn_v[0] = 1'b1;
        exec(0, ADDI, 3'b000, 0, 0, 4, "a_addi_after_illegal");
        chk("a_illegal_cleared", {31'd0, first_ctl.ill}, 0);
        chk("a_fetch_after_illegal", {31'd0, first_ctl.irw}, 1);
        exec(0, JALO, 3'b000, 0, 0, 4, "a_jal");
        exec(0, LUIO, 3'b000, 0, 0, 4, "a_lui");
        chk("a_instret3", ir_a, 3);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
